// File: rtl/seqdet_pkg.sv
// Shared definitions for the serial pattern detector and its serializer front end.
//   ser_state_t  : serializer FSM encoding
//   WIDTH_DEF    : default parallel word width
//   IDLE_BIT_DEF : default level driven on x while no word is being shifted
package seqdet_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int WIDTH_DEF    = 8;
    localparam bit IDLE_BIT_DEF = 1'b0;

endpackage

// File: rtl/seqdet_serializer.sv
// Parallel-to-serial front end for the serial pattern detector. Words arrive
// over a valid/ready handshake and leave one bit per clock on x. A one-word
// holding register lets consecutive words stream without an idle bit.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-low reset
//   din        parallel word, sampled when din_valid && din_ready
//   din_valid  upstream offers din
//   din_ready  a word can be accepted this cycle
//   x          serial bit to the detector (IDLE_BIT when not shifting)
//   x_valid    x carries a data bit this cycle
//   busy       shifting in progress or holding register full
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | shifter empty, x = IDLE_BIT, waiting for a word
// SHIFT | sreg driving x; cnt = index of the bit currently on x
module seqdet_serializer
    import seqdet_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = IDLE_BIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_t       state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] hold, hold_nxt;
    logic             hold_full, hold_full_nxt;
    logic             accept;
    logic [WIDTH-1:0] sreg_shifted;

    // Outputs depend only on registers, so the async reset clears them at once.
    assign din_ready = !hold_full;
    assign accept    = din_valid && din_ready;
    assign x_valid   = (state == SHIFT);
    assign busy      = (state == SHIFT) || hold_full;
    assign x         = (state == SHIFT) ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : IDLE_BIT;

    // Move the next bit toward the output end; the vacated bit fills with 0.
    assign sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sreg      <= '0;
            cnt       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            state     <= state_nxt;
            sreg      <= sreg_nxt;
            cnt       <= cnt_nxt;
            hold      <= hold_nxt;
            hold_full <= hold_full_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sreg_nxt      = sreg;
        cnt_nxt       = cnt;
        hold_nxt      = hold;
        hold_full_nxt = hold_full;
        case (state)
            IDLE: begin
                if (accept) begin
                    sreg_nxt  = din;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt != CNT_LAST) begin
                    sreg_nxt = sreg_shifted;
                    cnt_nxt  = cnt + CNT_W'(1);
                    if (accept) begin
                        hold_nxt      = din;
                        hold_full_nxt = 1'b1;
                    end
                end else if (hold_full) begin
                    // din_ready is low here, so no new word can compete with hold.
                    sreg_nxt      = hold;
                    hold_full_nxt = 1'b0;
                    cnt_nxt       = '0;
                end else if (accept) begin
                    // Word arriving on the last bit bypasses hold to stay gapless.
                    sreg_nxt = din;
                    cnt_nxt  = '0;
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seqdet_serializer.sv
module tb_seqdet_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic [7:0] din_a = '0;
    logic       valid_a = 1'b0;
    logic       ready_a, x_a, xv_a, busy_a;

    logic [7:0] din_b = '0;
    logic       valid_b = 1'b0;
    logic       ready_b, x_b, xv_b, busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seqdet_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .rst(rst), .din(din_a), .din_valid(valid_a),
        .din_ready(ready_a), .x(x_a), .x_valid(xv_a), .busy(busy_a)
    );

    seqdet_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .din(din_b), .din_valid(valid_b),
        .din_ready(ready_b), .x(x_b), .x_valid(xv_b), .busy(busy_b)
    );

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        checks++;
        if ({x_a, xv_a, ready_a, busy_a} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_init: x/xv/ready/busy got %b expected 0010", {x_a, xv_a, ready_a, busy_a});
        end
        checks++;
        if ({x_b, xv_b, ready_b, busy_b} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_init_lsb: x/xv/ready/busy got %b expected 1010", {x_b, xv_b, ready_b, busy_b});
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_single();
        logic [7:0] bits = 8'b1011_0010;
        din_a = 8'hB2; valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (x_a !== bits[7-k] || xv_a !== 1'b1) begin
                errors++;
                $display("FAIL single_bit%0d: x=%b xv=%b expected x=%b xv=1", k, x_a, xv_a, bits[7-k]);
            end
            step();
        end
        checks++;
        if ({x_a, xv_a, busy_a, ready_a} !== 4'b0001) begin
            errors++;
            $display("FAIL single_idle: x/xv/busy/ready got %b expected 0001", {x_a, xv_a, busy_a, ready_a});
        end
    endtask

    task automatic test_back_to_back();
        logic exp_x, exp_rdy;
        din_a = 8'hFF; valid_a = 1'b1;
        step();
        for (int c = 1; c <= 16; c++) begin
            exp_x   = (c <= 8);
            exp_rdy = (c == 1) || (c >= 9);
            checks++;
            if (x_a !== exp_x || xv_a !== 1'b1 || ready_a !== exp_rdy || busy_a !== 1'b1) begin
                errors++;
                $display("FAIL b2b_cycle%0d: x=%b xv=%b rdy=%b busy=%b expected x=%b xv=1 rdy=%b busy=1",
                         c, x_a, xv_a, ready_a, busy_a, exp_x, exp_rdy);
            end
            if (c == 1) din_a = 8'h00;
            if (c == 2) valid_a = 1'b0;
            step();
        end
        checks++;
        if ({xv_a, busy_a} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_end: xv/busy got %b expected 00", {xv_a, busy_a});
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] stream = 24'h3CC3A5;
        logic        exp_rdy;
        din_a = 8'h3C; valid_a = 1'b1;
        step();
        for (int c = 1; c <= 24; c++) begin
            exp_rdy = (c == 1) || (c == 9) || (c >= 17);
            checks++;
            if (x_a !== stream[24-c] || xv_a !== 1'b1 || ready_a !== exp_rdy) begin
                errors++;
                $display("FAIL bp_cycle%0d: x=%b xv=%b rdy=%b expected x=%b xv=1 rdy=%b",
                         c, x_a, xv_a, ready_a, stream[24-c], exp_rdy);
            end
            if (c == 1) din_a = 8'hC3;
            if (c == 2) din_a = 8'hA5;
            if (c == 10) valid_a = 1'b0;
            step();
        end
        checks++;
        if ({x_a, xv_a, busy_a} !== 3'b000) begin
            errors++;
            $display("FAIL bp_end: x/xv/busy got %b expected 000", {x_a, xv_a, busy_a});
        end
    endtask

    task automatic test_last_bit_load();
        logic [15:0] stream = 16'hAA0F;
        din_a = 8'hAA; valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            checks++;
            if (x_a !== stream[16-c] || xv_a !== 1'b1 || ready_a !== 1'b1) begin
                errors++;
                $display("FAIL lastload_cycle%0d: x=%b xv=%b rdy=%b expected x=%b xv=1 rdy=1",
                         c, x_a, xv_a, ready_a, stream[16-c]);
            end
            if (c == 8) begin din_a = 8'h0F; valid_a = 1'b1; end
            if (c == 9) valid_a = 1'b0;
            step();
        end
        checks++;
        if (xv_a !== 1'b0) begin
            errors++;
            $display("FAIL lastload_end: xv got %b expected 0", xv_a);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] bits = 8'b1000_0001;
        din_a = 8'hF0; valid_a = 1'b1;
        step();
        din_a = 8'h55;
        step();
        valid_a = 1'b0;
        checks++;
        if ({x_a, busy_a, ready_a} !== 3'b110) begin
            errors++;
            $display("FAIL rstmid_pre: x/busy/ready got %b expected 110", {x_a, busy_a, ready_a});
        end
        step();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({x_a, xv_a, ready_a, busy_a} !== 4'b0010) begin
            errors++;
            $display("FAIL rstmid_async: x/xv/ready/busy got %b expected 0010", {x_a, xv_a, ready_a, busy_a});
        end
        step();
        step();
        rst = 1'b1;
        checks++;
        if ({xv_a, busy_a} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_held: xv/busy got %b expected 00", {xv_a, busy_a});
        end
        din_a = 8'h81; valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (x_a !== bits[7-k] || xv_a !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_bit%0d: x=%b xv=%b expected x=%b xv=1", k, x_a, xv_a, bits[7-k]);
            end
            step();
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({x_a, xv_a, busy_a} !== 3'b000) begin
                errors++;
                $display("FAIL rstmid_after%0d: x/xv/busy got %b expected 000", k, {x_a, xv_a, busy_a});
            end
            step();
        end
    endtask

    task automatic test_lsb_idle_high();
        logic [7:0] bits = 8'b0000_0001;
        checks++;
        if ({x_b, xv_b} !== 2'b10) begin
            errors++;
            $display("FAIL lsb_idle_before: x/xv got %b expected 10", {x_b, xv_b});
        end
        din_b = 8'h01; valid_b = 1'b1;
        step();
        valid_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (x_b !== bits[k] || xv_b !== 1'b1) begin
                errors++;
                $display("FAIL lsb_bit%0d: x=%b xv=%b expected x=%b xv=1", k, x_b, xv_b, bits[k]);
            end
            step();
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({x_b, xv_b, busy_b} !== 3'b100) begin
                errors++;
                $display("FAIL lsb_idle_after%0d: x/xv/busy got %b expected 100", k, {x_b, xv_b, busy_b});
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_last_bit_load();
        test_reset_mid();
        test_lsb_idle_high();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
